pe: RTL and testbench



---
 rtl/pe.sv | 39 +++
 tb/tb_pe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// Multiply-accumulate processing element: unsigned BW x BW product added each
// cycle into a 2*BW-bit wrap-around accumulator that drives the output directly.
module pe #(
  parameter int BW = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [BW-1:0]     i_activation,
  input  logic [BW-1:0]     i_weight,
  output logic [2*BW-1:0]   o_output
);

  logic [2*BW-1:0] act_ext_s;
  logic [2*BW-1:0] wgt_ext_s;
  logic [2*BW-1:0] product_s;
  logic [2*BW-1:0] acc_d;
  logic [2*BW-1:0] acc_q;

  // Zero-extend operands so the product is computed at full 2*BW width, then
  // form the next accumulator value; the add wraps modulo 2^(2*BW) by width.
  always_comb begin
    act_ext_s = {{BW{1'b0}}, i_activation};
    wgt_ext_s = {{BW{1'b0}}, i_weight};
    product_s = act_ext_s * wgt_ext_s;
    acc_d     = acc_q + product_s;
  end

  // Accumulator register; reset clears it immediately, independent of the clock.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= {(2*BW){1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_output = acc_q;

endmodule

// File: tb/tb_pe.sv
// Directed self-checking bench for pe: one BW=8 instance for the main scenarios
// and one BW=4 instance for the parameterisation case.
`timescale 1ns/100ps
module tb_pe;

  logic        clk;
  logic        rst8;
  logic [7:0]  act8;
  logic [7:0]  wgt8;
  logic [15:0] out8;
  logic        rst4;
  logic [3:0]  act4;
  logic [3:0]  wgt4;
  logic [7:0]  out4;

  int checks;
  int failures;

  pe #(.BW(8)) dut8 (
    .i_clock      (clk),
    .i_reset      (rst8),
    .i_activation (act8),
    .i_weight     (wgt8),
    .o_output     (out8)
  );

  pe #(.BW(4)) dut4 (
    .i_clock      (clk),
    .i_reset      (rst4),
    .i_activation (act4),
    .i_weight     (wgt4),
    .o_output     (out4)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronously reset the BW=8 instance and release it at a falling edge.
  task automatic reset8();
    #0.3;
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
  endtask

  task automatic test_reset();
    int exp_v;
    #0.5;
    checks++;
    if (out8 !== 16'd0) begin
      failures++;
      $display("FAIL reset_async got=%0d exp=0", out8);
    end
    @(negedge clk);
    checks++;
    if (out8 !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold got=%0d exp=0", out8);
    end
    rst8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_v = i;
      checks++;
      if (out8 !== 16'(exp_v)) begin
        failures++;
        $display("FAIL reset_count%0d got=%0d exp=%0d", i, out8, exp_v);
      end
    end
  endtask

  task automatic test_accumulate();
    int exp_v;
    reset8();
    act8 = 8'd3;
    wgt8 = 8'd5;
    for (int i = 1; i <= 3; i++) begin
      // Glitch the operands between edges; only the edge-sampled values count.
      #0.3;
      act8 = 8'd200;
      wgt8 = 8'd200;
      #0.3;
      act8 = 8'd3;
      wgt8 = 8'd5;
      step();
      exp_v = 15 * i;
      checks++;
      if (out8 !== 16'(exp_v)) begin
        failures++;
        $display("FAIL accum%0d got=%0d exp=%0d", i, out8, exp_v);
      end
    end
    act8 = 8'd2;
    wgt8 = 8'd7;
    step();
    checks++;
    if (out8 !== 16'd59) begin
      failures++;
      $display("FAIL accum_mix got=%0d exp=59", out8);
    end
  endtask

  task automatic test_wrap();
    reset8();
    act8 = 8'd255;
    wgt8 = 8'd255;
    step();
    checks++;
    if (out8 !== 16'd65025) begin
      failures++;
      $display("FAIL wrap_first got=%0d exp=65025", out8);
    end
    step();
    checks++;
    if (out8 !== 16'd64514) begin
      failures++;
      $display("FAIL wrap_second got=%0d exp=64514", out8);
    end
  endtask

  task automatic test_hold_zero();
    reset8();
    act8 = 8'd2;
    wgt8 = 8'd5;
    step();
    checks++;
    if (out8 !== 16'd10) begin
      failures++;
      $display("FAIL hold_setup got=%0d exp=10", out8);
    end
    wgt8 = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (out8 !== 16'd10) begin
        failures++;
        $display("FAIL hold%0d got=%0d exp=10", i, out8);
      end
    end
  endtask

  task automatic test_async_reset();
    reset8();
    act8 = 8'd4;
    wgt8 = 8'd5;
    step();
    checks++;
    if (out8 !== 16'd20) begin
      failures++;
      $display("FAIL async_setup got=%0d exp=20", out8);
    end
    #0.5;
    rst8 = 1'b1;
    #0.1;
    checks++;
    if (out8 !== 16'd0) begin
      failures++;
      $display("FAIL async_clear got=%0d exp=0", out8);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (out8 !== 16'd0) begin
        failures++;
        $display("FAIL async_held%0d got=%0d exp=0", i, out8);
      end
    end
    rst8 = 1'b0;
    act8 = 8'd1;
    wgt8 = 8'd1;
    step();
    checks++;
    if (out8 !== 16'd1) begin
      failures++;
      $display("FAIL async_restart got=%0d exp=1", out8);
    end
  endtask

  task automatic test_bw4();
    checks++;
    if (out4 !== 8'd0) begin
      failures++;
      $display("FAIL bw4_reset got=%0d exp=0", out4);
    end
    act4 = 4'd15;
    wgt4 = 4'd15;
    rst4 = 1'b0;
    step();
    checks++;
    if (out4 !== 8'd225) begin
      failures++;
      $display("FAIL bw4_first got=%0d exp=225", out4);
    end
    step();
    checks++;
    if (out4 !== 8'd194) begin
      failures++;
      $display("FAIL bw4_wrap got=%0d exp=194", out4);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst8     = 1'b1;
    act8     = 8'd1;
    wgt8     = 8'd1;
    rst4     = 1'b1;
    act4     = 4'd0;
    wgt4     = 4'd0;
    test_reset();
    test_accumulate();
    test_wrap();
    test_hold_zero();
    test_async_reset();
    test_bw4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
